// File: rtl/sha_ctrl_pkg.sv
// Shared types and default sizes for the SHA multi-block control path.
package sha_ctrl_pkg;

  localparam int SHA256_IN_WORDS  = 16;
  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_OUT_WORDS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_ACC   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } sha_state_e;

  // Counter width that stays legal for a terminal count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tc_counter.sv
// Up-counter that saturates at a fixed terminal value; only clr restarts it.
module tc_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc    = (count_q == WIDTH'(TERMINAL));
  assign count = count_q;

  // Clear wins over enable; the count never runs past its terminal value.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && !tc)
      count_d = count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/sha_multiblock_sequencer.sv
// Sequences 1..MAX_BLOCKS message blocks through load, rounds, accumulate and
// digest write, with a start/busy/done handshake and a global stall.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | reading IN_WORDS message words of the current block
// ROUND | ROUNDS compression rounds
// ACC   | add working variables into the hash registers
// WRITE | writing OUT_WORDS digest words
// DONE  | one-cycle completion pulse
module sha_multiblock_sequencer
  import sha_ctrl_pkg::*;
#(
  parameter int IN_WORDS   = SHA256_IN_WORDS,
  parameter int ROUNDS     = SHA256_ROUNDS,
  parameter int OUT_WORDS  = SHA256_OUT_WORDS,
  parameter int MAX_BLOCKS = 4,
  parameter int IN_AW      = $clog2(MAX_BLOCKS * IN_WORDS),
  parameter int K_W        = $clog2(ROUNDS),
  parameter int OUT_AW     = $clog2(OUT_WORDS),
  parameter int BLK_W      = $clog2(MAX_BLOCKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BLK_W-1:0]  num_blocks,
  input  logic              stall,
  output logic [IN_AW-1:0]  in_mem_addr,
  output logic              in_mem_en,
  output logic              init_hash,
  output logic [K_W-1:0]    k_num,
  output logic              round_en,
  output logic              acc_en,
  output logic [BLK_W-1:0]  blk_idx,
  output logic [OUT_AW-1:0] out_mem_addr,
  output logic              en_mem_out,
  output logic              busy,
  output logic              done
);

  localparam int WORD_W = cnt_w(IN_WORDS);

  sha_state_e       state_q, state_d;
  logic [BLK_W-1:0] nblk_m1_q, nblk_m1_d, nblk_clamp;

  logic              word_en, word_clr, word_tc;
  logic              k_en, k_clr, k_tc;
  logic              out_en, out_clr, out_tc;
  logic              blk_en, blk_clr, blk_tc;
  logic [WORD_W-1:0] word_cnt;
  logic              last_blk;

  tc_counter #(.WIDTH(WORD_W), .TERMINAL(IN_WORDS - 1)) u_word_cnt (
    .clk(clk), .rst(reset), .en(word_en), .clr(word_clr), .count(word_cnt), .tc(word_tc)
  );

  tc_counter #(.WIDTH(K_W), .TERMINAL(ROUNDS - 1)) u_round_cnt (
    .clk(clk), .rst(reset), .en(k_en), .clr(k_clr), .count(k_num), .tc(k_tc)
  );

  tc_counter #(.WIDTH(OUT_AW), .TERMINAL(OUT_WORDS - 1)) u_out_cnt (
    .clk(clk), .rst(reset), .en(out_en), .clr(out_clr), .count(out_mem_addr), .tc(out_tc)
  );

  tc_counter #(.WIDTH(BLK_W), .TERMINAL(MAX_BLOCKS - 1)) u_blk_cnt (
    .clk(clk), .rst(reset), .en(blk_en), .clr(blk_clr), .count(blk_idx), .tc(blk_tc)
  );

  // Reaching the hardware block limit also ends the message, even if the
  // latched count were somehow larger.
  assign last_blk = blk_tc || (blk_idx == nblk_m1_q);

  // Next-state and counter control; stall freezes everything.
  always_comb begin
    state_d   = state_q;
    nblk_m1_d = nblk_m1_q;
    word_en   = 1'b0;
    word_clr  = 1'b0;
    k_en      = 1'b0;
    k_clr     = 1'b0;
    out_en    = 1'b0;
    out_clr   = 1'b0;
    blk_en    = 1'b0;
    blk_clr   = 1'b0;

    if (num_blocks == '0)
      nblk_clamp = '0;
    else if (num_blocks > BLK_W'(MAX_BLOCKS))
      nblk_clamp = BLK_W'(MAX_BLOCKS - 1);
    else
      nblk_clamp = num_blocks - 1'b1;

    if (!stall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_LOAD;
            nblk_m1_d = nblk_clamp;
            word_clr  = 1'b1;
            k_clr     = 1'b1;
            out_clr   = 1'b1;
            blk_clr   = 1'b1;
          end
        end
        ST_LOAD: begin
          if (word_tc) begin
            state_d = ST_ROUND;
            k_clr   = 1'b1;
          end else begin
            word_en = 1'b1;
          end
        end
        ST_ROUND: begin
          if (k_tc)
            state_d = ST_ACC;
          else
            k_en = 1'b1;
        end
        ST_ACC: begin
          if (last_blk) begin
            state_d = ST_WRITE;
            out_clr = 1'b1;
          end else begin
            state_d  = ST_LOAD;
            blk_en   = 1'b1;
            word_clr = 1'b1;
          end
        end
        ST_WRITE: begin
          if (out_tc)
            state_d = ST_DONE;
          else
            out_en = 1'b1;
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State and latched block count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      nblk_m1_q <= '0;
    end else begin
      state_q   <= state_d;
      nblk_m1_q <= nblk_m1_d;
    end
  end

  assign in_mem_addr = IN_AW'(blk_idx) * IN_AW'(IN_WORDS) + IN_AW'(word_cnt);

  assign in_mem_en  = (state_q == ST_LOAD)  && !stall;
  assign init_hash  = in_mem_en && (word_cnt == '0) && (blk_idx == '0);
  assign round_en   = (state_q == ST_ROUND) && !stall;
  assign acc_en     = (state_q == ST_ACC)   && !stall;
  assign en_mem_out = (state_q == ST_WRITE) && !stall;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_sha_multiblock_sequencer.sv
// Randomized bench: each message is expanded into a flat list of expected
// active cycles; the DUT consumes one entry per unstalled cycle.
module tb_sha_multiblock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] num_blocks;
  logic       stall;
  logic [5:0] in_mem_addr;
  logic       in_mem_en;
  logic       init_hash;
  logic [5:0] k_num;
  logic       round_en;
  logic       acc_en;
  logic [2:0] blk_idx;
  logic [2:0] out_mem_addr;
  logic       en_mem_out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  sha_multiblock_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks), .stall(stall),
    .in_mem_addr(in_mem_addr), .in_mem_en(in_mem_en), .init_hash(init_hash),
    .k_num(k_num), .round_en(round_en), .acc_en(acc_en), .blk_idx(blk_idx),
    .out_mem_addr(out_mem_addr), .en_mem_out(en_mem_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] all_outs();
    return {in_mem_addr, in_mem_en, init_hash, k_num, round_en, acc_en, blk_idx,
            out_mem_addr, en_mem_out, busy, done};
  endfunction

  // kind: 0 load, 1 round, 2 acc, 3 write, 4 done
  task automatic run_msg(input int nb, input int stall_pct, input bit noise);
    int  n, total, idx, stalls;
    int  kind[$];
    int  adr[$];
    int  blk[$];
    bit  fin, ns;
    logic [6:0] exp_v;
    n = (nb == 0) ? 1 : ((nb > 4) ? 4 : nb);
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < 16; w++) begin kind.push_back(0); adr.push_back(b*16 + w); blk.push_back(b); end
      for (int k = 0; k < 64; k++) begin kind.push_back(1); adr.push_back(k); blk.push_back(b); end
      kind.push_back(2); adr.push_back(0); blk.push_back(b);
    end
    for (int w = 0; w < 8; w++) begin kind.push_back(3); adr.push_back(w); blk.push_back(n-1); end
    kind.push_back(4); adr.push_back(7); blk.push_back(n-1);
    total = kind.size();

    @(negedge clk);
    start = 1'b1; num_blocks = 3'(nb); stall = 1'b0;
    @(posedge clk);
    idx = 0; stalls = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      #1;
      start      = (noise && idx < total - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      num_blocks = 3'($urandom_range(0, 7));
      stall      = ($urandom_range(0, 99) < stall_pct);
      @(negedge clk);
      ns = !stall;
      unique case (kind[idx])
        0: exp_v = {ns, ns && adr[idx] == 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        1: exp_v = {1'b0, 1'b0, ns, 1'b0, 1'b0, 1'b1, 1'b0};
        2: exp_v = {1'b0, 1'b0, 1'b0, ns, 1'b0, 1'b1, 1'b0};
        3: exp_v = {1'b0, 1'b0, 1'b0, 1'b0, ns, 1'b1, 1'b0};
        default: exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      endcase
      chk("strobes", {in_mem_en, init_hash, round_en, acc_en, en_mem_out, busy, done}, exp_v);
      chk("blk_idx", blk_idx, blk[idx]);
      unique case (kind[idx])
        0:       chk("in_mem_addr", in_mem_addr, adr[idx]);
        1:       chk("k_num", k_num, adr[idx]);
        2:       chk("k_num_acc", k_num, 63);
        default: chk("out_mem_addr", out_mem_addr, adr[idx]);
      endcase
      if (ns) begin
        if (kind[idx] == 4) begin
          chk("done_latency", cyc, n*81 + 8 + stalls);
          fin = 1'b1;
        end
        idx++;
      end else begin
        stalls++;
      end
      @(posedge clk);
    end
    if (!fin) chk("timeout", 0, 1);
    #1;
    stall = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_blocks = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    reset = 1'b0;

    run_msg(1, 0, 1'b0);
    run_msg(3, 0, 1'b0);
    run_msg(0, 0, 1'b0);
    run_msg(7, 0, 1'b0);
    run_msg(2, 15, 1'b1);
    for (int i = 0; i < 6; i++)
      run_msg($urandom_range(0, 7), $urandom_range(0, 30), 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of the round phase.
    @(negedge clk);
    start = 1'b1; num_blocks = 3'd2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (46) @(posedge clk);
    #1;
    chk("k_num_before_reset", k_num, 30);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    @(posedge clk);
    #1;
    chk("reset_held_outputs", all_outs(), 0);
    reset = 1'b0;
    run_msg(1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
